// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//   Responder end of the cache-to-memory request protocol. Serves icache
//   reads and dcache reads/writes over a single RAM port. Dcache has fixed
//   priority over icache. Every transfer is followed by one IDLE bubble.
//
//   Optional feature macro: MEMARB_STATS_EN
//     defined   : stat_dxfer / stat_ixfer / stat_stall are saturating counters
//     undefined : stat_* outputs tied to zero, no counter flops
//
// Parameters
//   TIMEOUT_CYCLES  non-ACCESS service cycles before err_timeout (1..255)
//
// Ports
//   CLK, nRST                 clock (rising), async active-low reset
//   iREN, iaddr               icache read request / word address
//   iwait, iload              0 = iload valid, icache transfer done this cycle
//   dREN, dWEN, daddr, dstore dcache read/write request, address, write data
//   dwait, dload              0 = dcache transfer done this cycle, read data
//   ramREN, ramWEN            RAM strobes
//   ramaddr, ramstore         RAM address / write data
//   ramload, ramstate         RAM read data / status (FREE,BUSY,ACCESS,ERROR)
//   err_timeout, err_proto    sticky error flags
//   stat_dxfer, stat_ixfer,
//   stat_stall                transfer / stall statistics
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err_timeout,
    output logic        err_proto,
    output logic [31:0] stat_dxfer,
    output logic [31:0] stat_ixfer,
    output logic [31:0] stat_stall
);

    typedef enum logic [1:0] {IDLE, DSERV, ISERV, RETRY} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

    state_t    r_state;
    state_t    w_next;
    ramstate_t w_rs;
    logic      r_owner_d;     // 1: current/retried transfer belongs to dcache
    logic [7:0] r_tcnt;
    logic      r_err_timeout;
    logic      r_err_proto;
    logic      w_dreq;
    logic      w_stall;       // service cycle, owner still requesting, no ACCESS
    logic      w_xfer_d;
    logic      w_xfer_i;

    assign w_rs        = ramstate_t'(ramstate);
    assign w_dreq      = dREN | dWEN;
    assign err_timeout = r_err_timeout;
    assign err_proto   = r_err_proto;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        w_stall  = 1'b0;
        w_xfer_d = 1'b0;
        w_xfer_i = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq) begin
                    w_next = DSERV;
                end else if (iREN) begin
                    w_next = ISERV;
                end
            end
            DSERV: begin
                if (!w_dreq) begin
                    w_next = IDLE;
                end else begin
                    // dREN & dWEN together is handled as a write
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (w_rs == RAM_ACCESS) begin
                        dwait    = 1'b0;
                        dload    = ramload;
                        w_xfer_d = 1'b1;
                        w_next   = IDLE;
                    end else begin
                        w_stall = 1'b1;
                        if (w_rs == RAM_ERROR) begin
                            w_next = RETRY;
                        end
                    end
                end
            end
            ISERV: begin
                if (!iREN) begin
                    w_next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (w_rs == RAM_ACCESS) begin
                        iwait    = 1'b0;
                        iload    = ramload;
                        w_xfer_i = 1'b1;
                        w_next   = IDLE;
                    end else begin
                        w_stall = 1'b1;
                        if (w_rs == RAM_ERROR) begin
                            w_next = RETRY;
                        end
                    end
                end
            end
            RETRY: begin
                if (r_owner_d) begin
                    w_next = w_dreq ? DSERV : IDLE;
                end else begin
                    w_next = iREN ? ISERV : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The timeout counter is cleared only in IDLE, so a RETRY round trip keeps
    // accumulating against the same transfer rather than restarting it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_owner_d     <= 1'b0;
            r_tcnt        <= '0;
            r_err_timeout <= 1'b0;
            r_err_proto   <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_owner_d <= w_dreq;
                r_tcnt    <= '0;
            end else if (w_stall && (r_tcnt != '1)) begin
                r_tcnt <= r_tcnt + 8'd1;
            end
            if (w_stall && (({24'd0, r_tcnt} + 32'd1) >= TIMEOUT_CYCLES)) begin
                r_err_timeout <= 1'b1;
            end
            if (dREN && dWEN) begin
                r_err_proto <= 1'b1;
            end
        end
    end

`ifdef MEMARB_STATS_EN
    logic [31:0] r_stat_dxfer;
    logic [31:0] r_stat_ixfer;
    logic [31:0] r_stat_stall;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stat_dxfer <= '0;
            r_stat_ixfer <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_xfer_d && (r_stat_dxfer != '1)) begin
                r_stat_dxfer <= r_stat_dxfer + 32'd1;
            end
            if (w_xfer_i && (r_stat_ixfer != '1)) begin
                r_stat_ixfer <= r_stat_ixfer + 32'd1;
            end
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_dxfer = r_stat_dxfer;
    assign stat_ixfer = r_stat_ixfer;
    assign stat_stall = r_stat_stall;
`else
    assign stat_dxfer = '0;
    assign stat_ixfer = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    localparam int unsigned TO = 4;
`ifdef MEMARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err_timeout, err_proto;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [31:0] stat_dxfer, stat_ixfer, stat_stall;

    cache_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .err_timeout(err_timeout), .err_proto(err_proto),
        .stat_dxfer(stat_dxfer), .stat_ixfer(stat_ixfer), .stat_stall(stat_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // m_own: 0 nobody being served, 1 dcache, 2 icache; m_retry: hold-off cycle
    int unsigned m_own = 0, m_cnt = 0;
    bit          m_retry = 1'b0, m_terr = 1'b0, m_perr = 1'b0;
    logic [31:0] m_dx = '0, m_ix = '0, m_st = '0;
    logic        e_iwait, e_dwait, e_ren, e_wen, m_req, dreq;
    logic [31:0] e_addr, e_store, e_iload, e_dload;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (!nRST) begin
                m_own = 0; m_retry = 1'b0; m_cnt = 0; m_terr = 1'b0; m_perr = 1'b0;
                m_dx = '0; m_ix = '0; m_st = '0;
            end
            chk1("err_timeout", err_timeout, m_terr);
            chk1("err_proto", err_proto, m_perr);
            chk("stat_dxfer", stat_dxfer, STATS ? m_dx : 32'd0);
            chk("stat_ixfer", stat_ixfer, STATS ? m_ix : 32'd0);
            chk("stat_stall", stat_stall, STATS ? m_st : 32'd0);

            e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
            e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
            if (nRST) begin
                dreq  = dREN | dWEN;
                m_req = (m_own == 1) ? dreq : iREN;
                if (m_own == 0) begin
                    m_cnt = 0;
                    m_own = dreq ? 1 : (iREN ? 2 : 0);
                end else if (m_retry) begin
                    m_retry = 1'b0;
                    if (!m_req) m_own = 0;
                end else if (!m_req) begin
                    m_own = 0;
                end else begin
                    if (m_own == 1) begin
                        e_wen = dWEN; e_ren = dREN & ~dWEN; e_addr = daddr; e_store = dstore;
                    end else begin
                        e_ren = 1'b1; e_addr = iaddr;
                    end
                    if (ramstate == ACCESS) begin
                        if (m_own == 1) begin
                            e_dwait = 1'b0; e_dload = ramload;
                            if (m_dx != '1) m_dx = m_dx + 1;
                        end else begin
                            e_iwait = 1'b0; e_iload = ramload;
                            if (m_ix != '1) m_ix = m_ix + 1;
                        end
                        m_own = 0;
                    end else begin
                        if (m_cnt < 255) m_cnt++;
                        if (m_cnt >= TO) m_terr = 1'b1;
                        if (m_st != '1) m_st = m_st + 1;
                        if (ramstate == ERROR) m_retry = 1'b1;
                    end
                end
                if (dREN && dWEN) m_perr = 1'b1;
            end
            chk1("iwait", iwait, e_iwait);
            chk1("dwait", dwait, e_dwait);
            chk1("ramREN", ramREN, e_ren);
            chk1("ramWEN", ramWEN, e_wen);
            chk("ramaddr", ramaddr, e_addr);
            chk("ramstore", ramstore, e_store);
            chk("iload", iload, e_iload);
            chk("dload", dload, e_dload);
            chk1("wait_exclusive", iwait | dwait, 1'b1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic ram(input logic [1:0] s, input logic [31:0] d);
        ramstate = s;
        ramload  = d;
    endtask

    task automatic dclr();
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dclr(); ram(FREE, '0);
        adv(); mon_en = 1'b1;
        @(negedge CLK);
        chk1("rst_iwait", iwait, 1'b1);
        chk1("rst_dwait", dwait, 1'b1);
        chk1("rst_ramREN", ramREN, 1'b0);
        adv(); nRST = 1'b1;

        // dcache read, two BUSY cycles then ACCESS
        dREN = 1'b1; daddr = 32'h40;
        @(negedge CLK); chk1("t1_idle_ren", ramREN, 1'b0); adv();
        ram(BUSY, '0);
        @(negedge CLK); chk1("t1_ren", ramREN, 1'b1); chk("t1_addr", ramaddr, 32'h40);
        chk1("t1_dwait_b1", dwait, 1'b1); adv();
        @(negedge CLK); chk1("t1_dwait_b2", dwait, 1'b1); adv();
        ram(ACCESS, 32'hDEADBEEF);
        @(negedge CLK); chk1("t1_dwait", dwait, 1'b0); chk("t1_dload", dload, 32'hDEADBEEF); adv();
        dclr(); ram(FREE, '0);
        @(negedge CLK); chk1("t1_dwait_after", dwait, 1'b1); adv();

        // iREN and dWEN together: dcache first, icache after the bubble
        iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        @(negedge CLK); adv();
        ram(BUSY, '0);
        @(negedge CLK); chk1("t2_wen", ramWEN, 1'b1); chk("t2_addr", ramaddr, 32'h80);
        chk("t2_store", ramstore, 32'h1234); chk1("t2_iwait_d", iwait, 1'b1); adv();
        ram(ACCESS, '0);
        @(negedge CLK); chk1("t2_dwait", dwait, 1'b0); chk1("t2_iwait_a", iwait, 1'b1); adv();
        dclr(); ram(FREE, '0);
        @(negedge CLK); chk1("t2_bubble_ren", ramREN, 1'b0); chk1("t2_bubble_iw", iwait, 1'b1); adv();
        ram(ACCESS, 32'hCAFE0001);
        @(negedge CLK); chk1("t2_iren", ramREN, 1'b1); chk("t2_iaddr", ramaddr, 32'h100);
        chk1("t2_iwait", iwait, 1'b0); chk("t2_iload", iload, 32'hCAFE0001); adv();
        iREN = 1'b0; ram(FREE, '0);
        @(negedge CLK); adv();

        // icache read with one ERROR -> RETRY -> reissue
        iREN = 1'b1; iaddr = 32'h200;
        @(negedge CLK); adv();
        ram(ERROR, '0);
        @(negedge CLK); chk1("t3_err_iwait", iwait, 1'b1); adv();
        ram(BUSY, '0);
        @(negedge CLK); chk1("t3_retry_ren", ramREN, 1'b0); chk1("t3_retry_iw", iwait, 1'b1); adv();
        @(negedge CLK); chk1("t3_reissue_ren", ramREN, 1'b1); chk1("t3_busy_iw", iwait, 1'b1); adv();
        ram(ACCESS, 32'h55AA);
        @(negedge CLK); chk1("t3_iwait", iwait, 1'b0); chk("t3_iload", iload, 32'h55AA); adv();
        iREN = 1'b0; ram(FREE, '0);
        @(negedge CLK); adv();

        // dREN & dWEN together: write issued, err_proto sticky
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h44; dstore = 32'h77;
        @(negedge CLK); chk1("t4_proto_pre", err_proto, 1'b0); adv();
        ram(ACCESS, '0);
        @(negedge CLK); chk1("t4_wen", ramWEN, 1'b1); chk1("t4_ren", ramREN, 1'b0);
        chk1("t4_proto", err_proto, 1'b1); chk1("t4_dwait", dwait, 1'b0); adv();
        dclr(); ram(FREE, '0);
        @(negedge CLK); adv();

        // two more zero-wait reads: 3 reads + 2 writes overall
        for (int k = 0; k < 2; k++) begin
            dREN = 1'b1; daddr = 32'h10 + 32'(k);
            @(negedge CLK); adv();
            ram(ACCESS, 32'hA0 + 32'(k));
            @(negedge CLK); chk("t5_dload", dload, 32'hA0 + 32'(k)); adv();
            dclr(); ram(FREE, '0);
            @(negedge CLK); adv();
        end
        @(negedge CLK);
        chk("t5_dxfer", stat_dxfer, STATS ? 32'd5 : 32'd0);
        chk("t5_ixfer", stat_ixfer, STATS ? 32'd2 : 32'd0);
        adv();

        // owner drops request mid-transfer
        dREN = 1'b1; daddr = 32'h60;
        @(negedge CLK); adv();
        ram(BUSY, '0);
        @(negedge CLK); chk1("t6_ren", ramREN, 1'b1); adv();
        dclr();
        @(negedge CLK); chk1("t6_drop_ren", ramREN, 1'b0); chk1("t6_drop_dw", dwait, 1'b1); adv();
        ram(FREE, '0);
        @(negedge CLK); chk("t6_dxfer", stat_dxfer, STATS ? 32'd5 : 32'd0); adv();

        // timeout: BUSY held for the whole transfer
        iREN = 1'b1; iaddr = 32'h300;
        @(negedge CLK); adv();
        ram(BUSY, '0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK); chk1("t7_to_low", err_timeout, 1'b0); adv();
        end
        @(negedge CLK); chk1("t7_to_set", err_timeout, 1'b1); chk1("t7_iw", iwait, 1'b1); adv();
        ram(ACCESS, 32'h99);
        @(negedge CLK); chk1("t7_iwait", iwait, 1'b0); adv();
        iREN = 1'b0; ram(FREE, '0);
        @(negedge CLK); chk1("t7_sticky", err_timeout, 1'b1); adv();

        // asynchronous reset in the middle of a write
        dWEN = 1'b1; daddr = 32'h90; dstore = 32'h5;
        @(negedge CLK); adv();
        ram(BUSY, '0);
        @(negedge CLK); chk1("t8_wen", ramWEN, 1'b1);
        #2 nRST = 1'b0;
        #1 chk1("t8_rst_wen", ramWEN, 1'b0); chk("t8_rst_addr", ramaddr, 32'h0);
        chk1("t8_rst_to", err_timeout, 1'b0); chk1("t8_rst_proto", err_proto, 1'b0);
        adv();
        @(negedge CLK); adv();
        nRST = 1'b1; dclr(); ram(FREE, '0);
        @(negedge CLK); chk1("t8_idle_dw", dwait, 1'b1); adv();
        @(negedge CLK); adv();

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
